// File: rtl/time_keeper.sv
// time_keeper: day/hour/minute real-time clock with a set mode and
// auto-repeating increment buttons.
module time_keeper #(
    parameter int g_clk_freq = 20000,
    parameter int g_btn_init = 20000,
    parameter int g_btn_hold = 5000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_set_time_n,
    input  logic       i_incr_day_n,
    input  logic       i_incr_hr_n,
    input  logic       i_incr_min_n,
    output logic [6:0] o_day,
    output logic [4:0] o_hour,
    output logic [5:0] o_minute
);
    localparam int CW = $clog2(g_clk_freq + 1);
    localparam int HMAX = g_btn_init > g_btn_hold ? g_btn_init : g_btn_hold;
    localparam int HW = $clog2(HMAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(g_clk_freq - 1);
    localparam logic [HW-1:0] INIT_LAST = HW'(g_btn_init - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(g_btn_hold - 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_REP  = 2'd2;

    logic [3:0]    sync1, sync2;
    logic          set_on;
    logic [2:0]    fire;
    logic [CW-1:0] cnt;
    logic [5:0]    sec;
    logic          sec_wrap, min_tick, hr_tick, day_tick;
    logic [5:0]    sec_inc, min_inc;
    logic [4:0]    hr_inc;
    logic [6:0]    day_inc;

    // bit3 = set, bit2 = day, bit1 = hour, bit0 = minute
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {i_set_time_n, i_incr_day_n, i_incr_hr_n, i_incr_min_n};
            sync2 <= sync1;
        end
    end

    assign set_on = ~sync2[3];

    for (genvar b = 0; b < 3; b++) begin : g_btn
        logic [1:0]    st;
        logic [HW-1:0] hold;
        logic          active;
        assign active = set_on & ~sync2[b];
        assign fire[b] = active & ((st == S_IDLE) | (st == S_INIT && hold == INIT_LAST) |
                                   (st == S_REP && hold == HOLD_LAST));
        // leaving set mode or releasing the button both count as a release
        always_ff @(posedge i_clk) begin
            if (i_reset || !active) begin
                st   <= S_IDLE;
                hold <= '0;
            end else begin
                st   <= (st == S_IDLE || (st == S_INIT && !fire[b])) ? S_INIT : S_REP;
                hold <= (st == S_IDLE || fire[b]) ? '0 : hold + HW'(1);
            end
        end
    end

    always_comb begin
        sec_wrap = cnt == CNT_LAST;
        min_tick = sec_wrap && sec == 6'd59;
        hr_tick  = min_tick && o_minute == 6'd59;
        day_tick = hr_tick && o_hour == 5'd23;
        sec_inc  = sec == 6'd59 ? '0 : sec + 6'd1;
        min_inc  = o_minute == 6'd59 ? '0 : o_minute + 6'd1;
        hr_inc   = o_hour == 5'd23 ? '0 : o_hour + 5'd1;
        day_inc  = {o_day[5:0], o_day[6]};
    end

    // in set mode each field steps only on its own button, so no carries
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt      <= '0;
            sec      <= '0;
            o_minute <= '0;
            o_hour   <= '0;
            o_day    <= 7'b0000001;
        end else begin
            cnt      <= (set_on || sec_wrap) ? '0 : cnt + CW'(1);
            sec      <= set_on ? '0 : sec_wrap ? sec_inc : sec;
            o_minute <= (set_on ? fire[0] : min_tick) ? min_inc : o_minute;
            o_hour   <= (set_on ? fire[1] : hr_tick) ? hr_inc : o_hour;
            o_day    <= (set_on ? fire[2] : day_tick) ? day_inc : o_day;
        end
    end
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed vectors for time_keeper with scaled-down timing
// (5 cycles per second, 5-cycle repeat delay, 1-cycle repeat period).
module tb_time_keeper;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       set_n = 1'b1, day_n = 1'b1, hr_n = 1'b1, min_n = 1'b1;
    logic [6:0] day;
    logic [4:0] hour;
    logic [5:0] minute;
    int         tests = 0;
    int         errors = 0;

    typedef struct {
        logic       set_n, day_n, hr_n, min_n;
        int         ticks;
        logic [6:0] day;
        logic [4:0] hour;
        logic [5:0] minute;
    } vec_t;

    vec_t vecs[14];

    time_keeper #(.g_clk_freq(5), .g_btn_init(5), .g_btn_hold(1)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_set_time_n(set_n),
        .i_incr_day_n(day_n),
        .i_incr_hr_n (hr_n),
        .i_incr_min_n(min_n),
        .o_day       (day),
        .o_hour      (hour),
        .o_minute    (minute)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [6:0] d, input logic [4:0] h,
                         input logic [5:0] m);
        tests++;
        if (day !== d || hour !== h || minute !== m) begin
            errors++;
            $display("FAIL %s: got day=%b %0d:%0d, expected day=%b %0d:%0d",
                     name, day, hour, minute, d, h, m);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_n = 1'b1;
        day_n = 1'b1;
        hr_n  = 1'b1;
        min_n = 1'b1;
        tick(2);
        check("reset", 7'b0000001, 5'd0, 6'd0);
        reset = 1'b0;
    endtask

    // one short press: seen pressed for exactly two edges, then back to idle
    task automatic pulse(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) min_n = 1'b0;
            else if (which == 1) hr_n = 1'b0;
            else day_n = 1'b0;
            tick(2);
            min_n = 1'b1;
            hr_n  = 1'b1;
            day_n = 1'b1;
            tick(3);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2,     7'b0000001, 5'd0,  6'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,     7'b0000010, 5'd1,  6'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4,     7'b0000010, 5'd1,  6'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,     7'b0000100, 5'd2,  6'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2,     7'b0010000, 5'd4,  6'd4};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,     7'b0100000, 5'd5,  6'd5};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,     7'b1000000, 5'd6,  6'd6};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8,     7'b1000000, 5'd14, 6'd14};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2,     7'b1000000, 5'd16, 6'd16};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 19,    7'b1000000, 5'd16, 6'd35};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 2,     7'b1000000, 5'd16, 6'd37};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 3,     7'b1000000, 5'd16, 6'd37};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 17996, 7'b1000000, 5'd17, 6'd36};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1,     7'b1000000, 5'd17, 6'd37};

        // free run from reset
        do_reset();
        tick(299);
        check("run_299", 7'b0000001, 5'd0, 6'd0);
        tick(1);
        check("run_300", 7'b0000001, 5'd0, 6'd1);
        tick(17699);
        check("run_17999", 7'b0000001, 5'd0, 6'd59);
        tick(1);
        check("run_18000", 7'b0000001, 5'd1, 6'd0);

        // all buttons held in set mode, then run an hour from Sat 16:37
        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_n = vecs[i].set_n;
            day_n = vecs[i].day_n;
            hr_n  = vecs[i].hr_n;
            min_n = vecs[i].min_n;
            tick(vecs[i].ticks);
            check($sformatf("vec%0d", i), vecs[i].day, vecs[i].hour, vecs[i].minute);
        end

        // manual wraps never carry
        set_n = 1'b0;
        tick(2);
        pulse(0, 22);
        check("min_to_59", 7'b1000000, 5'd17, 6'd59);
        pulse(0, 1);
        check("min_wrap", 7'b1000000, 5'd17, 6'd0);
        pulse(1, 6);
        check("hr_to_23", 7'b1000000, 5'd23, 6'd0);
        pulse(1, 1);
        check("hr_wrap", 7'b1000000, 5'd0, 6'd0);
        pulse(2, 1);
        check("day_wrap", 7'b0000001, 5'd0, 6'd0);

        // full carry chain from Saturday 23:59
        do_reset();
        set_n = 1'b0;
        tick(2);
        pulse(2, 6);
        pulse(1, 23);
        pulse(0, 59);
        check("preset", 7'b1000000, 5'd23, 6'd59);
        set_n = 1'b1;
        tick(2);
        tick(299);
        check("carry_299", 7'b1000000, 5'd23, 6'd59);
        tick(1);
        check("carry_300", 7'b0000001, 5'd0, 6'd0);

        // increments ignored in run mode; set pressed later is a new press
        day_n = 1'b0;
        hr_n  = 1'b0;
        min_n = 1'b0;
        tick(20);
        check("no_set", 7'b0000001, 5'd0, 6'd0);
        set_n = 1'b0;
        tick(3);
        check("late_set", 7'b0000010, 5'd1, 6'd1);
        tick(9);
        check("repeat", 7'b1000000, 5'd6, 6'd6);
        reset = 1'b1;
        tick(1);
        check("reset_mid", 7'b0000001, 5'd0, 6'd0);
        reset = 1'b0;
        set_n = 1'b1;
        day_n = 1'b1;
        hr_n  = 1'b1;
        min_n = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Real-time clock for the thermostat. Tracks day of week (one-hot), hour (0-23) and minute (0-59) from the 20 kHz system clock.
- Provides a user set mode. While the active-low set button is held, three active-low increment buttons adjust day, hour and minute.
- Each increment button fires once on press, then auto-repeats after an initial hold delay.
- Outputs feed the schedule and display logic.

Parameters:
- g_clk_freq, 20000: clock cycles per second; the seconds tick period.
- g_btn_init, 20000: cycles a button must be held after the first increment before auto-repeat starts (1 s).
- g_btn_hold, 5000: cycles between auto-repeat increments (0.25 s).

Ports:
- i_clk  in  1  system clock (20 kHz).
- i_reset  in  1  synchronous, active-high reset.
- i_set_time_n  in  1  set-mode enable, active low, asynchronous.
- i_incr_day_n  in  1  increment day, active low, asynchronous.
- i_incr_hr_n  in  1  increment hour, active low, asynchronous.
- i_incr_min_n  in  1  increment minute, active low, asynchronous.
- o_day  out  7  one-hot day: bit0 = Sunday … bit6 = Saturday.
- o_hour  out  5  hour, binary 0-23.
- o_minute  out  6  minute, binary 0-59.

Behaviour:
- One clock, i_clk. i_reset is synchronous and active-high; it is sampled on the rising edge of i_clk.
- Reset values:
  - o_day = 7'b0000001 (Sunday), o_hour = 0, o_minute = 0.
  - Internal seconds (0-59) and cycle counter = 0.
  - All button hold counters = 0.
  - Synchronizers = 1 (released).
- Input conditioning: all four button inputs pass through 2-flop synchronizers.
  - "Pressed" means the synchronized value is 0.
  - A manual increment becomes visible on the outputs at the 3rd rising edge after the input goes low.
- Run mode (set not pressed):
  - The cycle counter counts 0 to g_clk_freq-1. On wrap, seconds increments.
  - Seconds 59→0 carries to minute.
  - Minute 59→0 carries to hour.
  - Hour 23→0 carries to day.
  - Day rotates left one-hot: bit6 (Saturday) → bit0 (Sunday).
  - All carries resolve in the same cycle; the outputs update together.
  - Increment buttons are ignored in run mode and their hold counters are held at 0.
- Set mode (set pressed):
  - Cycle counter and seconds are held at 0; natural timekeeping is frozen.
  - Each increment button is handled independently with its own hold counter and state machine:
    - IDLE: on press → increment the field once → INIT.
    - INIT: count g_btn_init cycles → increment → REPEAT.
    - REPEAT: every g_btn_hold cycles → increment.
    - Release in any state → IDLE, counter cleared.
  - Manual increments wrap within their own field and never carry:
    - minute 59→0 (hour unchanged);
    - hour 23→0 (day unchanged);
    - day Saturday→Sunday.
  - Simultaneous presses of several increment buttons each act in the same cycle.
- Releasing set:
  - Returns to run mode with seconds = 0 and the cycle counter = 0.
  - Any in-progress auto-repeat stops immediately.
- Pressing set while a button is already held treats the button as a new press.
- Reset asserted mid-operation (run or set) overrides everything on that edge.
- Outputs are registered and never show illegal values:
  - hour ≤ 23, minute ≤ 59;
  - o_day always has exactly one bit set.

Test Plan:
- Simulation parameters: g_clk_freq = 5, g_btn_init = 5, g_btn_hold = 1.
- Reset then free run 300 cycles → o_minute = 1, o_hour = 0, o_day = 7'b0000001. After 18000 cycles → o_hour = 1, o_minute = 0.
- Carry chain: preset Saturday 23:59, run 300 cycles → o_day = 7'b0000001, o_hour = 0, o_minute = 0.
- Set mode with all increment buttons held from Sun 00:00:
  - First increment of each field 3 cycles after press; next at +5 cycles; then one per cycle.
  - Release day at o_day = 7'b1000000.
  - Release hour at 5'h10.
  - Release minute and set at 6'h25.
  - Result: Saturday 16:37 held stable.
- From Saturday 16:37:00 run → reaches Sunday (7'b0000001) 17:01 after (24*60+24)*300 cycles.
- Manual wrap: in set mode at minute 59, single press → minute 0, hour unchanged. Hour 23 press → 0, day unchanged.
- Increment buttons pressed without set → no output change. Assert i_reset during auto-repeat → Sun 00:00 on the next edge.
